// File: rtl/pipe_reg_hs_pkg.sv
// Shared constants and helpers for the handshaked register pipeline.
package pipe_reg_hs_pkg;

    // Datapath defaults used when the pipeline is dropped in without overrides.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 3;

    // Bits needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_hs_stage.sv
// One data+valid slice of the pipeline. It loads from upstream whenever the
// ready chain says this slot may move. Data only changes when a real beat
// arrives, so don't-care input data never lands in the slot.
module pipe_reg_hs_stage
    import pipe_reg_hs_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Reset beats flush. Flush drops every beat but leaves the data registers alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= in_valid;
            end
            if (!flush && load && in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_hs.sv
// DEPTH-stage, WIDTH-bit register pipeline with a per-beat handshake and
// bubble collapsing.
//
// Handshake: a beat is accepted when i_valid && o_ready. A beat is emitted
// when o_valid && i_ready. Both can happen in the same cycle. o_ready depends
// combinationally on i_ready and i_flush. It never depends on i_valid. Once
// o_valid is high, o_valor/o_valid stay put until the beat is taken. The only
// exceptions are flush and reset, which drop the beat.
module pipe_reg_hs
    import pipe_reg_hs_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter int               DEPTH      = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              i_valor,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [WIDTH-1:0]              o_valor,
    output logic                          o_valid,
    input  logic                          i_ready,
    input  logic                          i_flush,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] data           [DEPTH];
    logic [DEPTH-1:0] stage_rdy;
    logic [DEPTH-1:0] stage_in_valid;
    logic [WIDTH-1:0] stage_in_data  [DEPTH];
    logic             chain;

    // Ready chain: a slot can load if it is empty or its occupant moves on.
    // Walking from the output side lets any downstream hole pull beats forward.
    always_comb begin
        stage_rdy = '0;
        chain     = i_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain        = !v[k] | chain;
            stage_rdy[k] = chain;
        end
    end

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign stage_in_valid[k] = i_valid;
                assign stage_in_data[k]  = i_valor;
            end else begin : g_body
                assign stage_in_valid[k] = v[k-1];
                assign stage_in_data[k]  = data[k-1];
            end

            pipe_reg_hs_stage #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (i_flush),
                .load     (stage_rdy[k]),
                .in_valid (stage_in_valid[k]),
                .in_data  (stage_in_data[k]),
                .valid    (v[k]),
                .data     (data[k])
            );
        end
    endgenerate

    // Occupancy is the population count of the valid bits.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_count = o_count + CW'(v[i]);
        end
    end

    assign o_ready = stage_rdy[0] & !i_flush;
    assign o_valor = data[DEPTH-1];
    assign o_valid = v[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: directed scenarios plus a randomized run against a
// slot-position model, and a DEPTH=1 instance.
module tb_pipe_reg_hs;

    localparam int D = 3;
    localparam logic [7:0] RST_VAL = 8'h5A;

    logic       clk;
    logic       reset;
    logic [7:0] i_valor;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_valor;
    logic       o_valid;
    logic       i_ready;
    logic       i_flush;
    logic [1:0] o_count;

    logic [7:0] valor1;
    logic       valid1;
    logic       ready_out1;
    logic [7:0] valor_out1;
    logic       valid_out1;
    logic       ready1;
    logic [0:0] count1;

    int checks;
    int errors;

    // Model: beats oldest first, with the stage index each one occupies.
    logic [7:0] exp_q[$];
    int         m_pos[$];

    pipe_reg_hs #(.WIDTH(8), .DEPTH(D), .RESET_DATA(RST_VAL)) u_dut (
        .clk(clk), .reset(reset), .i_valor(i_valor), .i_valid(i_valid),
        .o_ready(o_ready), .o_valor(o_valor), .o_valid(o_valid),
        .i_ready(i_ready), .i_flush(i_flush), .o_count(o_count)
    );

    pipe_reg_hs #(.WIDTH(8), .DEPTH(1), .RESET_DATA(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .i_valor(valor1), .i_valid(valid1),
        .o_ready(ready_out1), .o_valor(valor_out1), .o_valid(valid_out1),
        .i_ready(ready1), .i_flush(1'b0), .o_count(count1)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A beat advances one slot if the slot ahead is free once older beats
    // have moved. Slot 0 frees up when nothing is there or its beat moves on.
    function automatic bit pred_ready();
        int  limit;
        int  np;
        int  last;
        bit  emit;
        if (i_flush) return 1'b0;
        if (m_pos.size() == 0) return 1'b1;
        emit  = (m_pos[0] == D - 1) && i_ready;
        limit = D;
        last  = 1;
        for (int i = emit ? 1 : 0; i < m_pos.size(); i++) begin
            np = m_pos[i] + 1;
            if (np >= limit) np = m_pos[i];
            limit = np;
            last  = np;
        end
        return last != 0;
    endfunction

    function automatic bit exp_valid();
        return (m_pos.size() > 0) && (m_pos[0] == D - 1);
    endfunction

    // Advance one clock. The model is updated from the inputs present at the edge.
    task automatic tick();
        bit acc;
        bit emit;
        int limit;
        acc  = i_valid && pred_ready();
        emit = exp_valid() && i_ready;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_pos.delete();
        end else begin
            if (emit) begin
                void'(exp_q.pop_front());
                void'(m_pos.pop_front());
            end
            if (i_flush) begin
                exp_q.delete();
                m_pos.delete();
            end else begin
                limit = D;
                foreach (m_pos[i]) begin
                    if (m_pos[i] + 1 < limit) m_pos[i] = m_pos[i] + 1;
                    limit = m_pos[i];
                end
                if (acc) begin
                    exp_q.push_back(i_valor);
                    m_pos.push_back(0);
                end
            end
        end
        #1;
    endtask

    task automatic set_in(input bit v, input logic [7:0] d, input bit r, input bit f);
        i_valid = v;
        i_valor = d;
        i_ready = r;
        i_flush = f;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 8'h00, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++;
        if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        checks++;
        if (o_valor !== RST_VAL) begin errors++; $display("FAIL reset_valor: got %h want %h", o_valor, RST_VAL); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_flush: got %b want 0", o_ready); end
        i_flush = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int first_seen;
        int emitted;
        int max_cnt;
        first_seen = -1;
        emitted    = 0;
        max_cnt    = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            set_in(cyc < 5, 8'(cyc + 1), 1, 0);
            #1;
            checks++;
            if (o_ready !== pred_ready()) begin errors++; $display("FAIL stream_ready cyc %0d: got %b want %b", cyc, o_ready, pred_ready()); end
            checks++;
            if (o_valid !== exp_valid()) begin errors++; $display("FAIL stream_valid cyc %0d: got %b want %b", cyc, o_valid, exp_valid()); end
            if (o_valid && first_seen < 0) first_seen = cyc;
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            if (o_valid) begin
                emitted++;
                checks++;
                if (o_valor !== 8'(emitted)) begin errors++; $display("FAIL stream_order: got %h want %h", o_valor, 8'(emitted)); end
            end
            tick();
        end
        checks++;
        if (first_seen !== 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", first_seen); end
        checks++;
        if (emitted !== 5) begin errors++; $display("FAIL stream_emitted: got %0d want 5", emitted); end
        checks++;
        if (max_cnt !== 3) begin errors++; $display("FAIL stream_maxcount: got %0d want 3", max_cnt); end
    endtask

    task automatic test_stall();
        int acc_cnt;
        logic [7:0] got[$];
        acc_cnt = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            set_in(1, 8'(acc_cnt + 1), 0, 0);
            #1;
            if (o_valid) begin
                checks++;
                if (o_valor !== 8'h01) begin errors++; $display("FAIL stall_hold: got %h want 01", o_valor); end
            end
            if (o_ready) acc_cnt++;
            tick();
        end
        #1;
        checks++;
        if (acc_cnt !== 3) begin errors++; $display("FAIL stall_accepts: got %0d want 3", acc_cnt); end
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", o_ready); end
        checks++;
        if (o_count !== 2'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", o_count); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_in(0, 8'hFF, 1, 0);
            #1;
            if (o_valid) got.push_back(o_valor);
            tick();
        end
        checks++;
        if (got.size() !== 3) begin errors++; $display("FAIL stall_drain_len: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL stall_drain[%0d]: got %h want %h", i, got[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_bubble();
        int         exp_cnt[5];
        bit         pat_v[5];
        logic [7:0] pat_d[5];
        logic [7:0] got[$];
        exp_cnt = '{1, 1, 2, 2, 3};
        pat_v   = '{1, 0, 1, 0, 1};
        pat_d   = '{8'hA0, 8'hXX, 8'hA1, 8'hXX, 8'hA2};
        for (int i = 0; i < 5; i++) begin
            set_in(pat_v[i], pat_d[i], 0, 0);
            tick();
            checks++;
            if (int'(o_count) !== exp_cnt[i]) begin errors++; $display("FAIL bubble_count[%0d]: got %0d want %0d", i, o_count, exp_cnt[i]); end
        end
        set_in(0, 8'h00, 0, 0);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL bubble_full_ready: got %b want 0", o_ready); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_in(0, 8'h00, 1, 0);
            #1;
            if (o_valid) got.push_back(o_valor);
            tick();
        end
        checks++;
        if (got.size() !== 3) begin errors++; $display("FAIL bubble_drain_len: got %0d want 3", got.size()); end
        else begin
            checks++;
            if (got[0] !== 8'hA0 || got[1] !== 8'hA1 || got[2] !== 8'hA2) begin
                errors++; $display("FAIL bubble_drain: got %h %h %h want a0 a1 a2", got[0], got[1], got[2]);
            end
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        set_in(1, 8'hB0, 0, 0); tick();
        set_in(1, 8'hB1, 0, 0); tick();
        checks++;
        if (o_count !== 2'd2) begin errors++; $display("FAIL flush_precount: got %0d want 2", o_count); end
        set_in(1, 8'hEE, 0, 1);
        #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", o_ready); end
        tick();
        set_in(0, 8'h00, 0, 0);
        #1;
        checks++;
        if (o_count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", o_count); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_in(0, 8'h00, 1, 0);
            #1;
            if (o_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_leak: got %0d beats want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 8'(8'hC0 + i), 0, 0);
            tick();
        end
        checks++;
        if (o_count !== 2'd3) begin errors++; $display("FAIL rstmid_full: got %0d want 3", o_count); end
        reset = 1'b1;
        set_in(1, 8'hCC, 1, 1);
        tick();
        reset = 1'b0;
        set_in(0, 8'h00, 0, 0);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        checks++;
        if (o_count !== 2'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", o_count); end
        checks++;
        if (o_valor !== RST_VAL) begin errors++; $display("FAIL rstmid_valor: got %h want %h", o_valor, RST_VAL); end
        for (int cyc = 0; cyc < 4; cyc++) begin
            set_in(0, 8'h00, 1, 0);
            #1;
            if (o_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rstmid_leak: got %0d beats want 0", seen); end
    endtask

    task automatic test_random();
        int ready_pct;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ready_pct = (cyc / 100) % 2 == 0 ? 80 : 30;
            reset = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3) != 0,
                   8'($urandom_range(0, 255)),
                   $urandom_range(0, 99) < ready_pct,
                   $urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (o_ready !== pred_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, o_ready, pred_ready()); end
            checks++;
            if (o_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, o_valid, exp_valid()); end
            checks++;
            if (int'(o_count) !== m_pos.size()) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, o_count, m_pos.size()); end
            if (exp_valid()) begin
                checks++;
                if (o_valor !== exp_q[0]) begin errors++; $display("FAIL rnd_valor cyc %0d: got %h want %h", cyc, o_valor, exp_q[0]); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_depth1();
        logic [7:0] q1[$];
        logic [7:0] next_d;
        int         acc_n;
        int         emit_n;
        bit         acc;
        next_d = 8'h10;
        acc_n  = 0;
        emit_n = 0;
        reset  = 1'b1;
        set_in(0, 8'h00, 0, 0);
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 44; cyc++) begin
            valid1 = (cyc < 40);
            valor1 = next_d;
            ready1 = (cyc % 2 == 0) || (cyc >= 40);
            #1;
            checks++;
            if (ready_out1 !== (!valid_out1 | ready1)) begin
                errors++; $display("FAIL d1_ready cyc %0d: got %b want %b", cyc, ready_out1, !valid_out1 | ready1);
            end
            if (valid_out1 && ready1) begin
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL d1_spurious cyc %0d: got %h want none", cyc, valor_out1); end
                else begin
                    if (valor_out1 !== q1[0]) begin errors++; $display("FAIL d1_order cyc %0d: got %h want %h", cyc, valor_out1, q1[0]); end
                    void'(q1.pop_front());
                end
                emit_n++;
            end
            acc = valid1 && ready_out1;
            tick();
            if (acc) begin
                checks++;
                if (valid_out1 !== 1'b1 || valor_out1 !== next_d) begin
                    errors++; $display("FAIL d1_latency cyc %0d: got %b/%h want 1/%h", cyc, valid_out1, valor_out1, next_d);
                end
                q1.push_back(next_d);
                next_d = next_d + 8'h01;
                acc_n++;
            end
        end
        checks++;
        if (q1.size() !== 0 || emit_n !== acc_n || acc_n < 15) begin
            errors++; $display("FAIL d1_loss: got %0d emitted of %0d accepted, %0d left want all emitted", emit_n, acc_n, q1.size());
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        valid1  = 1'b0;
        valor1  = 8'h00;
        ready1  = 1'b0;
        set_in(0, 8'h00, 0, 0);
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
        test_reset_mid();
        test_random();
        test_depth1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_hs.md
Name: pipe_reg_hs

Overview:
Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with a valid/ready handshake per beat. Stalls from downstream propagate back through the stages. Empty stages (bubbles) collapse so no slot is wasted. It adds flush and an occupancy count, and is the standard retiming/decoupling element between datapath blocks.

Parameters:
WIDTH, 8, data bits per beat (>=1)
DEPTH, 3, number of register stages (>=1); no-stall latency in cycles
RESET_DATA, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_valor  input  WIDTH  upstream data
i_valid  input  1  upstream beat present
o_ready  output  1  pipeline accepts a beat this cycle
o_valor  output  WIDTH  data of last stage (DEPTH-1)
o_valid  output  1  last stage holds a beat
i_ready  input  1  downstream accepts this cycle
i_flush  input  1  discard all held beats
o_count  output  clog2(DEPTH+1)  number of occupied stages

Behaviour:
- Clocking: one clock, clk. Reset is synchronous, active-high, on port reset, sampled at the rising edge.
- State:
  - per stage k (0 = input side, DEPTH-1 = output side): data[k] (WIDTH bits) and v[k] (1 bit).
  - o_valor = data[DEPTH-1]; o_valid = v[DEPTH-1].
- Ready chain (combinational from registers and i_ready):
  - rdy[DEPTH] = i_ready.
  - rdy[k] = !v[k] | rdy[k+1].
  - o_ready = rdy[0] & !i_flush.
- Transfer: accept when i_valid & o_ready; emit when o_valid & i_ready. Both may occur in the same cycle.
- Stage update at the edge, when rdy[k] is true:
  - v[k] <= incoming valid (i_valid for k=0, v[k-1] otherwise).
  - data[k] <= incoming data, only if incoming valid is 1; otherwise data[k] holds.
  - When rdy[k] is false, the stage holds both data and valid.
- Data stability: a valid beat at the output holds o_valor/o_valid unchanged until i_ready=1. Bubbles must collapse, e.g. v=101 with i_ready=0 advances to v=011 next cycle.
- Latency: a beat accepted in cycle n is presented on o_valor in cycle n+DEPTH when there are no stalls. Throughput is 1 beat/cycle with i_ready held at 1.
- Full pipeline (all v=1, i_ready=0): o_ready=0 and nothing moves. With all v=1 and i_ready=1: o_ready=1, so simultaneous accept and emit keeps the pipeline full.
- Flush:
  - When i_flush=1, all v[k] <= 0 at the edge.
  - o_ready is forced to 0, so no beat is accepted in that cycle.
  - o_valid may still be 1 during the flush cycle. A downstream handshake in that cycle counts as a legal emit.
  - Data registers are not cleared.
- Reset:
  - v[k] <= 0 and data[k] <= RESET_DATA for all k.
  - Outputs after reset: o_valid=0, o_valor=RESET_DATA, o_count=0, o_ready=!i_flush.
  - Reset wins over flush and over any handshake. Reset mid-operation drops all beats with no partial output.
- o_count: population count of v[], combinational from registers, range 0..DEPTH.
- X-safety: i_valor is don't-care when i_valid=0 and must never reach a stage marked valid.
- DEPTH=1: degenerates to a single registered slice with combinational ready = !v | i_ready.

Decomposition:
- Shared package:
  - count-width function clog2(DEPTH+1).
  - default WIDTH/DEPTH constants for the team's datapath.
- Natural sub-module: pipe_stage (one data+valid slice with incoming valid/data, rdy_in, flush, reset). Instantiate it DEPTH times in a generate loop; the top level builds the rdy chain and the popcount.

Test Plan:
- WIDTH=8, DEPTH=3, i_ready=1, stream 0x01..0x05 back-to-back -> 0x01 appears 3 cycles after acceptance, then one beat/cycle in order; o_count reaches 3.
- i_ready=0, i_valid=1 continuously -> exactly 3 beats accepted, o_ready=0 afterwards, o_count=3, o_valor holds 0x01 stable; release i_ready -> 0x01,0x02,0x03 drain with no loss or duplication.
- Bubble: send 0xA0, idle 1 cycle, send 0xA1, with i_ready=0 -> stages compress to v=111 only after a third beat; o_count tracks 1,1,2,2,3.
- Flush with o_count=2 and i_valid=1 in the flush cycle -> o_ready=0 that cycle, o_count=0 next cycle, the input beat is never emitted.
- Reset asserted mid-stream with pipeline full -> next cycle o_valid=0, o_count=0, o_valor=RESET_DATA; a reset+flush in the same cycle behaves as reset.
- DEPTH=1 build: alternate i_ready 1/0 with continuous input -> latency 1, o_ready equals !o_valid | i_ready every cycle, no beat lost.
